// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage controller: FSM state encoding,
// branch-type encodings, default parameters and the branch decision helper.
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_EQ     = 2'b01,
        BR_NE     = 2'b10,
        BR_ALWAYS = 2'b11
    } branch_t;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_MAX_WAIT = 8;

    // Branch decision from the branch type and the ALU zero flag.
    function automatic logic branch_taken(input logic [1:0] br, input logic zero);
        logic taken;
        taken = 1'b0;
        case (br)
            BR_EQ:     taken = zero;
            BR_NE:     taken = ~zero;
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge bus between the MEM stage (master) and the
// multi-cycle data memory (slave).
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              DmReq;
    logic              DmWe;
    logic [DATA_W-1:0] DmAddr;
    logic [DATA_W-1:0] DmWData;
    logic              DmAck;
    logic [DATA_W-1:0] DmRData;

    modport master (
        output DmReq, DmWe, DmAddr, DmWData,
        input  DmAck, DmRData
    );

    modport slave (
        input  DmReq, DmWe, DmAddr, DmWData,
        output DmAck, DmRData
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding data-memory access. Cleared when an
// access is issued, advanced on every WAIT cycle that does not complete, and
// flags expiry once MAX_WAIT cycles have gone by without an acknowledge.
module mem_wait_timer #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count;

    // Counter: clear has priority over enable so a fresh access starts at zero.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_stage.sv
// MEM-stage controller: performs the data-memory access held in EX/MEM over a
// req/ack handshake, resolves branches, stalls upstream while an access is
// outstanding and registers the MEM/WB fields for writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              ValidIn,
    input  logic [DATA_W-1:0] BranchAddResultIn,
    input  logic [DATA_W-1:0] ALUResultIn,
    input  logic [DATA_W-1:0] MemDataIn,
    input  logic [4:0]        rdRegIn,
    input  logic              RegWriteIn,
    input  logic              MemWriteIn,
    input  logic              MemReadIn,
    input  logic              MemToRegIn,
    input  logic              ZeroIn,
    input  logic [1:0]        BranchIn,
    mem_stage_if.master       dm,
    output logic              PCSrc,
    output logic [DATA_W-1:0] BranchTarget,
    output logic              StallOut,
    output logic              ValidOut,
    output logic              RegWriteOut,
    output logic              MemToRegOut,
    output logic              MemErrOut,
    output logic [DATA_W-1:0] ReadDataOut,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic [4:0]        rdRegOut
);

    state_t state;
    logic   memop;
    logic   in_idle;
    logic   in_wait;
    logic   expired;
    logic   done;
    logic   timeout;
    logic   read_ack;

    assign memop   = ValidIn & (MemReadIn | MemWriteIn);
    assign in_idle = (state == ST_IDLE);
    assign in_wait = (state == ST_WAIT);

    // An acknowledge on the expiry cycle wins, so a timeout needs no ack.
    assign done     = in_wait & (dm.DmAck | expired);
    assign timeout  = in_wait & ~dm.DmAck & expired;
    assign read_ack = in_wait & dm.DmAck & ~dm.DmWe;

    assign StallOut     = (in_idle & memop) | (in_wait & ~done);
    assign PCSrc        = ValidIn & ~StallOut & branch_taken(BranchIn, ZeroIn);
    assign BranchTarget = BranchAddResultIn;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .Reset_n (Reset_n),
        .clear   (in_idle & memop),
        .enable  (in_wait & ~done),
        .expired (expired)
    );

    // Access FSM: latch the request on issue, hold it stable until completion.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            dm.DmReq   <= 1'b0;
            dm.DmWe    <= 1'b0;
            dm.DmAddr  <= '0;
            dm.DmWData <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (memop) begin
                        state      <= ST_WAIT;
                        dm.DmReq   <= 1'b1;
                        dm.DmWe    <= MemWriteIn;
                        dm.DmAddr  <= ALUResultIn;
                        dm.DmWData <= MemDataIn;
                    end
                end
                ST_WAIT: begin
                    if (done) begin
                        state    <= ST_IDLE;
                        dm.DmReq <= 1'b0;
                    end
                end
            endcase
        end
    end

    // MEM/WB register: capture when not stalled, otherwise insert a bubble.
    always_ff @(posedge clk) begin
        if (!Reset_n || StallOut) begin
            ValidOut     <= 1'b0;
            RegWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
            MemErrOut    <= 1'b0;
            ReadDataOut  <= '0;
            ALUResultOut <= '0;
            rdRegOut     <= '0;
        end else begin
            ValidOut     <= ValidIn;
            RegWriteOut  <= RegWriteIn & ValidIn & ~timeout;
            MemToRegOut  <= MemToRegIn;
            MemErrOut    <= timeout;
            ReadDataOut  <= read_ack ? dm.DmRData : '0;
            ALUResultOut <= ALUResultIn;
            rdRegOut     <= rdRegIn;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int MAXW = 4;

    logic        clk;
    logic        Reset_n;
    logic        ValidIn;
    logic [31:0] BranchAddResultIn;
    logic [31:0] ALUResultIn;
    logic [31:0] MemDataIn;
    logic [4:0]  rdRegIn;
    logic        RegWriteIn, MemWriteIn, MemReadIn, MemToRegIn, ZeroIn;
    logic [1:0]  BranchIn;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        StallOut;
    logic        ValidOut, RegWriteOut, MemToRegOut, MemErrOut;
    logic [31:0] ReadDataOut, ALUResultOut;
    logic [4:0]  rdRegOut;

    mem_stage_if #(.DATA_W(32)) dm_bus ();

    mem_stage #(
        .DATA_W   (32),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk               (clk),
        .Reset_n           (Reset_n),
        .ValidIn           (ValidIn),
        .BranchAddResultIn (BranchAddResultIn),
        .ALUResultIn       (ALUResultIn),
        .MemDataIn         (MemDataIn),
        .rdRegIn           (rdRegIn),
        .RegWriteIn        (RegWriteIn),
        .MemWriteIn        (MemWriteIn),
        .MemReadIn         (MemReadIn),
        .MemToRegIn        (MemToRegIn),
        .ZeroIn            (ZeroIn),
        .BranchIn          (BranchIn),
        .dm                (dm_bus),
        .PCSrc             (PCSrc),
        .BranchTarget      (BranchTarget),
        .StallOut          (StallOut),
        .ValidOut          (ValidOut),
        .RegWriteOut       (RegWriteOut),
        .MemToRegOut       (MemToRegOut),
        .MemErrOut         (MemErrOut),
        .ReadDataOut       (ReadDataOut),
        .ALUResultOut      (ALUResultOut),
        .rdRegOut          (rdRegOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy;      // an access has been issued and not yet finished
    int          m_cnt;       // WAIT cycles elapsed without an acknowledge
    bit          m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    bit          w_valid, w_rw, w_m2r, w_err;
    logic [31:0] w_rdata, w_alu;
    logic [4:0]  w_rd;

    function automatic bit m_memop();
        return ValidIn && (MemReadIn || MemWriteIn);
    endfunction

    // Upstream must freeze unless nothing is pending or the pending access finishes now.
    function automatic bit m_stall();
        if (!m_busy) return m_memop();
        return !(DmAckNow() || m_cnt == MAXW);
    endfunction

    function automatic bit DmAckNow();
        return dm_bus.DmAck == 1'b1;
    endfunction

    function automatic bit m_taken();
        case (BranchIn)
            2'b01:   return ZeroIn == 1'b1;
            2'b10:   return ZeroIn == 1'b0;
            2'b11:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Single compare process: advance the model at each edge, check mid-cycle.
    initial begin
        bit st;
        forever begin
            @(posedge clk);
            if (!Reset_n) begin
                m_busy = 0; m_cnt = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
                w_valid = 0; w_rw = 0; w_m2r = 0; w_err = 0; w_rdata = 0; w_alu = 0; w_rd = 0;
            end else begin
                st = m_stall();
                if (st) begin
                    w_valid = 0; w_rw = 0; w_m2r = 0; w_err = 0; w_rdata = 0; w_alu = 0; w_rd = 0;
                end else begin
                    w_valid = ValidIn;
                    w_err   = m_busy && !DmAckNow();
                    w_rw    = RegWriteIn && ValidIn && !w_err;
                    w_m2r   = MemToRegIn;
                    w_rdata = (m_busy && DmAckNow() && !m_we) ? dm_bus.DmRData : 32'h0;
                    w_alu   = ALUResultIn;
                    w_rd    = rdRegIn;
                end
                if (!m_busy) begin
                    if (m_memop()) begin
                        m_busy = 1; m_cnt = 0; m_req = 1;
                        m_we = MemWriteIn; m_addr = ALUResultIn; m_wdata = MemDataIn;
                    end
                end else if (!st) begin
                    m_busy = 0; m_req = 0;
                end else begin
                    m_cnt++;
                end
            end
            @(negedge clk);
            #2;
            if (chk_en) begin
                chk("cmp_stall", 32'(StallOut), 32'(m_stall()));
                chk("cmp_pcsrc", 32'(PCSrc), 32'(ValidIn && !m_stall() && m_taken()));
                chk("cmp_btarget", BranchTarget, BranchAddResultIn);
                chk("cmp_req", 32'(dm_bus.DmReq), 32'(m_req));
                if (m_req) begin
                    chk("cmp_addr", dm_bus.DmAddr, m_addr);
                    chk("cmp_we", 32'(dm_bus.DmWe), 32'(m_we));
                    chk("cmp_wdata", dm_bus.DmWData, m_wdata);
                end
                chk("cmp_valid", 32'(ValidOut), 32'(w_valid));
                chk("cmp_regwrite", 32'(RegWriteOut), 32'(w_rw));
                chk("cmp_memtoreg", 32'(MemToRegOut), 32'(w_m2r));
                chk("cmp_memerr", 32'(MemErrOut), 32'(w_err));
                chk("cmp_rdata", ReadDataOut, w_rdata);
                chk("cmp_alu", ALUResultOut, w_alu);
                chk("cmp_rd", 32'(rdRegOut), 32'(w_rd));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(negedge clk);
        #3;
    endtask

    task automatic idle();
        ValidIn = 0; BranchAddResultIn = 0; ALUResultIn = 0; MemDataIn = 0; rdRegIn = 0;
        RegWriteIn = 0; MemWriteIn = 0; MemReadIn = 0; MemToRegIn = 0; ZeroIn = 0; BranchIn = 2'b00;
        dm_bus.DmAck = 0; dm_bus.DmRData = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit held;
        int kind;
        held = 0;
        idle();
        Reset_n = 0;
        next();
        next();
        Reset_n = 1;
        chk_en = 1;
        #1;
        chk("rst_req", 32'(dm_bus.DmReq), 32'h0);
        chk("rst_addr", dm_bus.DmAddr, 32'h0);
        chk("rst_valid", 32'(ValidOut), 32'h0);
        chk("rst_stall", 32'(StallOut), 32'h0);

        // Load, acknowledged after three WAIT cycles.
        next(); idle();
        ValidIn = 1; MemReadIn = 1; RegWriteIn = 1; MemToRegIn = 1; ALUResultIn = 32'h100; rdRegIn = 5'd7;
        #1 chk("ld_stall_issue", 32'(StallOut), 32'h1);
        for (int k = 0; k < 3; k++) begin
            next();
            #1;
            chk("ld_req", 32'(dm_bus.DmReq), 32'h1);
            chk("ld_addr", dm_bus.DmAddr, 32'h100);
            chk("ld_we", 32'(dm_bus.DmWe), 32'h0);
            chk("ld_stall_wait", 32'(StallOut), 32'h1);
            chk("ld_bubble", 32'(ValidOut), 32'h0);
        end
        next(); dm_bus.DmAck = 1; dm_bus.DmRData = 32'hDEADBEEF;
        #1 chk("ld_stall_ack", 32'(StallOut), 32'h0);
        next(); idle();
        #1;
        chk("ld_valid", 32'(ValidOut), 32'h1);
        chk("ld_rdata", ReadDataOut, 32'hDEADBEEF);
        chk("ld_regwrite", 32'(RegWriteOut), 32'h1);
        chk("ld_rd", 32'(rdRegOut), 32'h7);
        chk("ld_req_drop", 32'(dm_bus.DmReq), 32'h0);
        next();
        #1;
        chk("ld_one_cycle", 32'(ValidOut), 32'h0);
        chk("ld_rw_one_cycle", 32'(RegWriteOut), 32'h0);

        // Store, acknowledged on the second WAIT cycle.
        next(); idle();
        ValidIn = 1; MemWriteIn = 1; ALUResultIn = 32'h40; MemDataIn = 32'h12345678;
        next();
        #1;
        chk("st_we", 32'(dm_bus.DmWe), 32'h1);
        chk("st_wdata", dm_bus.DmWData, 32'h12345678);
        chk("st_addr", dm_bus.DmAddr, 32'h40);
        next(); dm_bus.DmAck = 1; dm_bus.DmRData = 32'hAAAA5555;
        #1 chk("st_wdata_hold", dm_bus.DmWData, 32'h12345678);
        next(); idle();
        #1;
        chk("st_valid", 32'(ValidOut), 32'h1);
        chk("st_rdata", ReadDataOut, 32'h0);
        chk("st_regwrite", 32'(RegWriteOut), 32'h0);

        // Branch resolution.
        next(); idle();
        ValidIn = 1; BranchAddResultIn = 32'h00400020; BranchIn = 2'b01; ZeroIn = 1;
        #1;
        chk("br_eq_taken", 32'(PCSrc), 32'h1);
        chk("br_target", BranchTarget, 32'h00400020);
        next(); BranchIn = 2'b10;
        #1 chk("br_ne_not", 32'(PCSrc), 32'h0);
        next(); BranchIn = 2'b11; ValidIn = 0;
        #1 chk("br_always_invalid", 32'(PCSrc), 32'h0);
        next(); ValidIn = 1;
        #1 chk("br_always", 32'(PCSrc), 32'h1);

        // Timeout with no acknowledge, then a run acknowledged on the expiry cycle.
        for (int run = 0; run < 2; run++) begin
            next(); idle();
            ValidIn = 1; MemReadIn = 1; RegWriteIn = 1; ALUResultIn = 32'h200; rdRegIn = 5'd3;
            dm_bus.DmRData = 32'h55555555;
            for (int k = 0; k < MAXW; k++) begin
                next();
                #1 chk("to_stall", 32'(StallOut), 32'h1);
            end
            next();
            if (run == 1) begin
                dm_bus.DmAck = 1; dm_bus.DmRData = 32'hCAFEF00D;
            end
            #1 chk("to_stall_drop", 32'(StallOut), 32'h0);
            next(); idle();
            #1;
            chk("to_valid", 32'(ValidOut), 32'h1);
            chk("to_memerr", 32'(MemErrOut), (run == 0) ? 32'h1 : 32'h0);
            chk("to_regwrite", 32'(RegWriteOut), (run == 0) ? 32'h0 : 32'h1);
            chk("to_rdata", ReadDataOut, (run == 0) ? 32'h0 : 32'hCAFEF00D);
        end

        // Reset on the second WAIT cycle; a late acknowledge is ignored.
        next(); idle();
        ValidIn = 1; MemReadIn = 1; RegWriteIn = 1; ALUResultIn = 32'h300;
        next();
        next(); idle(); Reset_n = 0;
        next(); Reset_n = 1; dm_bus.DmAck = 1; dm_bus.DmRData = 32'h11112222;
        #1;
        chk("rw_req", 32'(dm_bus.DmReq), 32'h0);
        chk("rw_addr", dm_bus.DmAddr, 32'h0);
        chk("rw_stall", 32'(StallOut), 32'h0);
        chk("rw_valid", 32'(ValidOut), 32'h0);
        next(); idle();
        #1;
        chk("rw_late_ack_valid", 32'(ValidOut), 32'h0);
        chk("rw_late_ack_rdata", ReadDataOut, 32'h0);

        // Back-to-back non-memory instructions.
        for (int i = 0; i < 5; i++) begin
            next(); idle();
            ValidIn = 1; RegWriteIn = 1; ALUResultIn = 32'h1000 + 32'(i); rdRegIn = 5'(i);
            #1 chk("alu_stall", 32'(StallOut), 32'h0);
            if (i > 0) begin
                chk("alu_valid", 32'(ValidOut), 32'h1);
                chk("alu_result", ALUResultOut, 32'h1000 + 32'(i - 1));
            end
        end
        next(); idle();
        #1;
        chk("alu_valid_last", 32'(ValidOut), 32'h1);
        chk("alu_result_last", ALUResultOut, 32'h1004);

        // Randomized traffic; EX/MEM inputs freeze while the DUT stalls.
        held = 0;
        for (int i = 0; i < 3000; i++) begin
            next();
            Reset_n = ($urandom_range(0, 59) != 0);
            if (!held) begin
                kind = int'($urandom_range(0, 3));
                ValidIn           = ($urandom_range(0, 4) != 0);
                MemReadIn         = (kind == 0);
                MemWriteIn        = (kind == 1);
                MemToRegIn        = (kind == 0);
                RegWriteIn        = 1'($urandom_range(0, 1));
                ALUResultIn       = $urandom;
                MemDataIn         = $urandom;
                BranchAddResultIn = $urandom;
                BranchIn          = 2'($urandom_range(0, 3));
                ZeroIn            = 1'($urandom_range(0, 1));
                rdRegIn           = 5'($urandom_range(0, 31));
            end
            if (dm_bus.DmReq) dm_bus.DmAck = ($urandom_range(0, 2) == 0);
            else dm_bus.DmAck = ($urandom_range(0, 15) == 0);
            dm_bus.DmRData = $urandom;
            #1 held = StallOut;
        end

        next(); idle();
        next();
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
